// File: rtl/tdc_phase_decoder.sv
// TDC back-end: decodes sampled ring phases plus ripple count into a fine total and
// emits the per-reference-period delta, optionally summed over 2^avg_sel periods.
module tdc_phase_decoder #(
  parameter int unsigned NPH     = 16,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned AVG_MAX = 7,
  localparam int unsigned FRAC_W = $clog2(2 * NPH),
  localparam int unsigned TOT_W  = CNT_W + FRAC_W,
  localparam int unsigned OUT_W  = TOT_W + AVG_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NPH-1:0]   phase,
  input  logic [CNT_W-1:0] ripple_count,
  input  logic [2:0]       avg_sel,
  output logic [OUT_W-1:0] tdc_out,
  output logic             tdc_valid,
  output logic             bubble_err,
  output logic [7:0]       bubble_cnt
);

  localparam int unsigned TR_W = $clog2(NPH + 1);
  localparam int unsigned WC_W = AVG_MAX + 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  // R1: input capture
  logic             en_r;
  logic [NPH-1:0]   phase_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       sel_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r    <= 1'b0;
      phase_r <= '0;
      cnt_r   <= '0;
      sel_r   <= '0;
    end else begin
      en_r    <= en;
      phase_r <= phase;
      cnt_r   <= ripple_count;
      sel_r   <= avg_sel;
    end
  end

  // Decode: run length from bit 0 and circular transition count
  logic [FRAC_W-1:0] run_len;
  logic              run_open;
  logic [TR_W-1:0]   trans;
  logic [FRAC_W-1:0] frac_raw;
  logic [FRAC_W-1:0] frac;
  logic              bubble;
  logic [FRAC_W-1:0] frac_prev_q;
  logic [TOT_W-1:0]  total;
  logic [TOT_W-1:0]  total_prev_q;
  logic [TOT_W-1:0]  delta;

  always_comb begin
    run_len  = FRAC_W'(1);
    run_open = 1'b1;
    trans    = '0;
    for (int i = 1; i < NPH; i++) begin
      if (run_open && (phase_r[i] == phase_r[0])) begin
        run_len = run_len + FRAC_W'(1);
      end else begin
        run_open = 1'b0;
      end
    end
    for (int i = 0; i < NPH; i++) begin
      trans = trans + TR_W'(phase_r[i] != phase_r[(i + 1) % NPH]);
    end
    frac_raw = phase_r[0] ? (run_len - FRAC_W'(1))
                          : (FRAC_W'(NPH) + run_len - FRAC_W'(1));
    bubble   = (trans > TR_W'(2));
    frac     = bubble ? frac_prev_q : frac_raw;
    total    = {cnt_r, frac};
    // Modular difference absorbs ripple counter wrap
    delta    = total - total_prev_q;
  end

  // FSM on the registered enable
  state_e state_q, state_d;
  logic   delta_ok;

  always_comb begin
    state_d  = state_q;
    delta_ok = 1'b0;
    if (!en_r) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StPrime;
        StPrime: begin
          state_d  = StRun;
          delta_ok = 1'b1;
        end
        StRun: begin
          state_d  = StRun;
          delta_ok = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // R2: decode results
  logic             en2_q;
  logic             dv_q;
  logic [TOT_W-1:0] delta_q;
  logic [2:0]       sel2_q;
  logic             bubble_err_q;
  logic [7:0]       bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      frac_prev_q  <= '0;
      total_prev_q <= '0;
      en2_q        <= 1'b0;
      dv_q         <= 1'b0;
      delta_q      <= '0;
      sel2_q       <= '0;
      bubble_err_q <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      en2_q        <= en_r;
      dv_q         <= delta_ok;
      delta_q      <= delta;
      sel2_q       <= sel_r;
      bubble_err_q <= bubble;
      if (!bubble) frac_prev_q <= frac_raw;
      if (en_r) total_prev_q <= total;
      if (bubble && (bubble_cnt_q != 8'hFF)) bubble_cnt_q <= bubble_cnt_q + 8'd1;
    end
  end

  // R3: window accumulation
  logic [2:0]       win_q;
  logic [WC_W-1:0]  wcnt_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] tdc_out_q;
  logic             tdc_valid_q;
  logic [2:0]       sel_clamp;
  logic [2:0]       win_eff;
  logic [WC_W-1:0]  win_len_m1;
  logic [OUT_W-1:0] acc_sum;

  always_comb begin
    sel_clamp = sel2_q;
    if (int'(sel2_q) > int'(AVG_MAX)) sel_clamp = 3'(AVG_MAX);
    // A window's length is fixed by the sample that opens it
    win_eff    = (wcnt_q == '0) ? sel_clamp : win_q;
    win_len_m1 = WC_W'((1 << win_eff) - 1);
    acc_sum    = acc_q + OUT_W'(delta_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      wcnt_q      <= '0;
      acc_q       <= '0;
      tdc_out_q   <= '0;
      tdc_valid_q <= 1'b0;
    end else if (!en2_q) begin
      wcnt_q      <= '0;
      acc_q       <= '0;
      tdc_valid_q <= 1'b0;
    end else if (dv_q) begin
      if (wcnt_q == '0) win_q <= sel_clamp;
      if (wcnt_q == win_len_m1) begin
        tdc_out_q   <= acc_sum;
        tdc_valid_q <= 1'b1;
        acc_q       <= '0;
        wcnt_q      <= '0;
      end else begin
        acc_q       <= acc_sum;
        wcnt_q      <= wcnt_q + WC_W'(1);
        tdc_valid_q <= 1'b0;
      end
    end else begin
      tdc_valid_q <= 1'b0;
    end
  end

  assign tdc_out    = tdc_out_q;
  assign tdc_valid  = tdc_valid_q;
  assign bubble_err = bubble_err_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Directed-vector bench for tdc_phase_decoder with a per-sample behavioural model.
module tb_tdc_phase_decoder;

  localparam int NPH   = 16;
  localparam int OUT_W = 19;
  localparam int NV    = 700;

  logic              clk;
  logic              rst;
  logic              en;
  logic [NPH-1:0]    phase;
  logic [6:0]        ripple_count;
  logic [2:0]        avg_sel;
  logic [OUT_W-1:0]  tdc_out;
  logic              tdc_valid;
  logic              bubble_err;
  logic [7:0]        bubble_cnt;

  tdc_phase_decoder #(.NPH(16), .CNT_W(7), .AVG_MAX(7)) dut (
    .clk(clk), .rst(rst), .en(en), .phase(phase), .ripple_count(ripple_count),
    .avg_sel(avg_sel), .tdc_out(tdc_out), .tdc_valid(tdc_valid),
    .bubble_err(bubble_err), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus table; v_lit is a hand-computed tdc_out for that sample (-1 = none)
  logic        v_en  [NV];
  logic [15:0] v_ph  [NV];
  logic [6:0]  v_cnt [NV];
  logic [2:0]  v_sel [NV];
  logic        v_rst [NV];
  int          v_lit [NV];
  int          nv = 0;

  int compared = 0;
  int mismatched = 0;

  task automatic add(input logic e, input logic [15:0] ph, input logic [6:0] c,
                     input logic [2:0] s, input logic r, input int lit);
    v_en[nv] = e; v_ph[nv] = ph; v_cnt[nv] = c; v_sel[nv] = s; v_rst[nv] = r;
    v_lit[nv] = lit;
    nv++;
  endtask

  // Generator: count steps +62/+63 while frac alternates 0/16 -> 2000 per period
  int g_cnt;
  bit g_odd;
  task automatic gen_start(input int c);
    g_cnt = c; g_odd = 1'b0;
  endtask
  task automatic gen_adv();
    g_cnt = (g_cnt + (g_odd ? 63 : 62)) % 128;
    g_odd = ~g_odd;
  endtask
  task automatic gen(input logic e, input logic [2:0] s, input int lit);
    add(e, g_odd ? 16'hFFFE : 16'h0001, 7'(g_cnt), s, 1'b0, lit);
    gen_adv();
  endtask

  function automatic int transitions(input logic [15:0] p);
    int t = 0;
    for (int i = 0; i < NPH; i++) if (p[i] != p[(i + 1) % NPH]) t++;
    return t;
  endfunction

  function automatic int frac_of(input logic [15:0] p);
    int k = 1;
    while (k < NPH && p[k] == p[0]) k++;
    return p[0] ? k - 1 : NPH + k - 1;
  endfunction

  // Model state
  int last_rst = -1;
  bit primed;
  int prev_total, good_frac, bcnt, acc, n, win, m_out;
  bit m_valid, m_err;
  bit d_en [NV];
  bit d_dv [NV];
  int d_delta [NV];
  int d_sel [NV];

  task automatic chk(input string name, input int c, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, c, act, exp);
    end
  endtask

  task automatic model_edge(input int c);
    int j, cnt, f, total, d, sel;
    logic [15:0] ph;
    bit e;
    if (v_rst[c]) begin
      last_rst = c; primed = 0; prev_total = 0; good_frac = 0; bcnt = 0;
      acc = 0; n = 0; win = 0; m_out = 0; m_valid = 0; m_err = 0;
      return;
    end
    // Window accumulation of sample c-2 (decoded at edge c-1)
    j = c - 2;
    m_valid = 0;
    e = (j >= 0 && (c - 1) > last_rst) ? d_en[j] : 1'b0;
    if (!e) begin
      acc = 0; n = 0;
    end else if (d_dv[j]) begin
      if (n == 0) win = (d_sel[j] > 7) ? 7 : d_sel[j];
      acc += d_delta[j];
      n++;
      if (n == (1 << win)) begin
        m_out = acc; m_valid = 1; acc = 0; n = 0;
      end
    end
    // Decode of sample c-1; samples swallowed by reset look like all-zero words
    j = c - 1;
    if (j >= 0 && j > last_rst) begin
      e = v_en[j]; ph = v_ph[j]; cnt = v_cnt[j]; sel = v_sel[j];
    end else begin
      e = 0; ph = 16'h0000; cnt = 0; sel = 0;
    end
    m_err = (transitions(ph) > 2);
    if (m_err) begin
      f = good_frac;
      if (bcnt < 255) bcnt++;
    end else begin
      f = frac_of(ph);
      good_frac = f;
    end
    total = cnt * 32 + f;
    if (j >= 0) begin
      d_en[j] = e; d_sel[j] = sel; d_dv[j] = 0; d_delta[j] = 0;
    end
    if (e) begin
      d = total - prev_total;
      if (d < 0) d += 4096;
      if (j >= 0) begin
        d_dv[j] = primed; d_delta[j] = d;
      end
      prev_total = total;
      primed = 1;
    end else begin
      primed = 0;
    end
  endtask

  task automatic drive(input int c);
    rst = v_rst[c]; en = v_en[c]; phase = v_ph[c]; ripple_count = v_cnt[c];
    avg_sel = v_sel[c];
  endtask

  initial begin
    // Power-up reset and idle
    add(0, 16'h0, 0, 0, 1, -1);
    add(0, 16'h0, 0, 0, 1, -1);
    add(0, 16'h0, 0, 0, 0, -1);
    add(0, 16'h0, 0, 0, 0, -1);
    // Decode pinning: frac 0 -> 7 -> 23 -> 15 -> 31 -> next count frac 0
    add(1, 16'h0001, 5, 0, 0, -1);
    add(1, 16'h00FF, 5, 0, 0, 7);
    add(1, 16'hFF00, 5, 0, 0, 16);
    add(1, 16'hFFFF, 5, 0, 0, 4088);
    add(1, 16'h0000, 5, 0, 0, 16);
    add(1, 16'h0001, 6, 0, 0, 1);
    add(0, 16'h0, 0, 0, 0, -1);
    add(0, 16'h0, 0, 0, 0, -1);
    // Direct mode
    gen_start(0);
    gen(1, 0, -1);
    repeat (9) gen(1, 0, 2000);
    add(0, 16'h0, 0, 0, 0, -1);
    // Counter wrap
    gen_start(100);
    gen(1, 0, -1);
    repeat (9) gen(1, 0, 2000);
    // Averaging over 4, then a mid-window switch back to direct
    for (int i = 0; i < 8; i++) gen(1, 2, (i % 4 == 3) ? 8000 : -1);
    gen(1, 2, -1);
    gen(1, 2, -1);
    gen(1, 0, -1);
    gen(1, 0, 8000);
    repeat (3) gen(1, 0, 2000);
    // Bubble on a frac-16 slot: previous frac 0 substituted
    if (!g_odd) gen(1, 0, 2000);
    add(1, 16'h0F0F, 7'(g_cnt), 0, 0, 1984);
    gen_adv();
    gen(1, 0, 2016);
    repeat (3) gen(1, 0, 2000);
    // Enable drop mid-window discards partial sum
    gen(1, 2, -1);
    gen(1, 2, -1);
    gen(1, 2, -1);
    add(0, 16'h0, 0, 0, 0, -1);
    gen_start(10);
    gen(1, 0, -1);
    repeat (2) gen(1, 0, 2000);
    // Bubble counter saturation while disabled
    repeat (258) add(0, 16'h0F0F, 0, 0, 0, -1);
    add(0, 16'h0, 0, 0, 0, -1);
    // Reset mid-window, then re-prime
    gen_start(20);
    repeat (6) gen(1, 3, -1);
    add(1, 16'h0001, 0, 3, 1, -1);
    gen_start(40);
    gen(1, 0, -1);
    repeat (4) gen(1, 0, 2000);
    repeat (3) add(0, 16'h0, 0, 0, 0, -1);

    drive(0);
    for (int c = 0; c < nv; c++) begin
      @(posedge clk);
      #1;
      model_edge(c);
      chk("tdc_out", c, int'(tdc_out), m_out);
      chk("tdc_valid", c, int'(tdc_valid), int'(m_valid));
      chk("bubble_err", c, int'(bubble_err), int'(m_err));
      chk("bubble_cnt", c, int'(bubble_cnt), bcnt);
      if (c >= 2 && v_lit[c-2] >= 0) begin
        chk("literal_valid", c, int'(tdc_valid), 1);
        chk("literal_out", c, int'(tdc_out), v_lit[c-2]);
      end
      @(negedge clk);
      if (c + 1 < nv) begin
        drive(c + 1);
        if (v_rst[c+1]) begin
          #1;
          chk("rst_zero", c + 1, int'({tdc_out, tdc_valid, bubble_err, bubble_cnt}), 0);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
